// File: rtl/memory_unit.sv
// ---------------------------------------------------------------------------
// memory_unit
//
// Memory pipeline stage controller. It holds the instruction leaving execute,
// checks its ARM condition code against the live flags and runs the data-RAM
// req/ack handshake with a timeout watchdog. While an access is outstanding
// the upstream stages are frozen through stall_mem.
//
// Ports
//   clk, rst_n          stage clock, asynchronous active-low reset
//   instr_in/opcode_in  instruction and opcode from execute
//   pc_in               PC of instr_in
//   bubble_in           execute is stalled: capture a NOP instead
//   flags_in            NZCV (bit3=N .. bit0=V)
//   mem_ack             data RAM finished the access this cycle
//   rn/rd/opcode/sel_w_addr1 _memory   forwarding info for execute
//   sel_addr            0 = ALU result address, 1 = A operand (post-index)
//   mem_req, ram_r_en, ram_w_en        data RAM control
//   stall_mem           freeze fetch/decode/execute this cycle
//   mem_err             sticky timeout flag (cleared by reset only)
//   instr_output, pc_out, opcode_out   towards the wait stage
// ---------------------------------------------------------------------------
module memory_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_in,
  input  logic [6:0]  opcode_in,
  input  logic [6:0]  pc_in,
  input  logic        bubble_in,
  input  logic [3:0]  flags_in,
  input  logic        mem_ack,
  output logic [3:0]  rn_memory,
  output logic [3:0]  rd_memory,
  output logic [6:0]  opcode_memory,
  output logic [1:0]  sel_w_addr1_memory,
  output logic        sel_addr,
  output logic        mem_req,
  output logic        ram_r_en,
  output logic        ram_w_en,
  output logic        stall_mem,
  output logic        mem_err,
  output logic [31:0] instr_output,
  output logic [6:0]  pc_out,
  output logic [6:0]  opcode_out
);

  localparam logic [6:0]  OP_NOP    = 7'b0100000;
  localparam logic [31:0] INSTR_NOP = 32'hE320F000;
  localparam int          CW        = (TIMEOUT > 16) ? $clog2(TIMEOUT) : 4;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  // Standard ARM condition decode; flags = {N, Z, C, V}.
  function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, r;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    case (cond)
      4'b0000: r = z;
      4'b0001: r = !z;
      4'b0010: r = c;
      4'b0011: r = !c;
      4'b0100: r = n;
      4'b0101: r = !n;
      4'b0110: r = v;
      4'b0111: r = !v;
      4'b1000: r = c && !z;
      4'b1001: r = !c || z;
      4'b1010: r = (n == v);
      4'b1011: r = (n != v);
      4'b1100: r = !z && (n == v);
      4'b1101: r = z || (n != v);
      4'b1110: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_mem_op(input logic [6:0] op);
    return (op[6:4] == 3'b110) || (op[6:3] == 4'b1000) || (op[6:4] == 3'b111);
  endfunction

  // Held stage state
  logic [31:0]   instr_q;
  logic [6:0]    opcode_q;
  logic [6:0]    pc_q;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          mem_err_q;

  // Held-opcode classes
  logic is_ldr, is_ldr_lit, is_str, is_alu;
  assign is_ldr     = (opcode_q[6:4] == 3'b110);
  assign is_ldr_lit = (opcode_q[6:3] == 4'b1000);
  assign is_str     = (opcode_q[6:4] == 3'b111);
  assign is_alu     = !opcode_q[6] && (opcode_q != OP_NOP);

  logic cond_pass, live, abort;
  assign cond_pass = cond_ok(instr_q[31:28], flags_in);
  // Gate with the current condition too, so an access whose condition stops
  // holding (flags changed under it) is treated as squashed, not left hanging.
  assign live      = (state_q == ACCESS) && cond_pass;
  assign abort     = live && !mem_ack && (cnt_q == CNT_LAST);
  assign stall_mem = live && !mem_ack && !abort;

  // Capture path
  logic        cap_mem;
  logic [31:0] cap_instr;
  logic [6:0]  cap_op;
  assign cap_instr = bubble_in ? INSTR_NOP : instr_in;
  assign cap_op    = bubble_in ? OP_NOP : opcode_in;
  assign cap_mem   = !bubble_in && is_mem_op(opcode_in) && cond_ok(instr_in[31:28], flags_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q   <= INSTR_NOP;
      opcode_q  <= OP_NOP;
      pc_q      <= '0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      if (abort)
        mem_err_q <= 1'b1;
      if (!stall_mem) begin
        // Ack, abort or idle: accept the next instruction at this edge.
        instr_q  <= cap_instr;
        opcode_q <= cap_op;
        pc_q     <= pc_in;
        state_q  <= cap_mem ? ACCESS : IDLE;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Forwarding outputs follow the held instruction for the whole stall.
  assign rn_memory = instr_q[19:16];
  assign rd_memory = instr_q[15:12];
  assign opcode_memory = (!cond_pass || abort) ? OP_NOP : opcode_q;

  always_comb begin
    sel_w_addr1_memory = 2'b00;
    if (cond_pass) begin
      if (is_alu)
        sel_w_addr1_memory = 2'b01;
      else if ((is_ldr || is_str) && (!instr_q[24] || instr_q[21]))
        sel_w_addr1_memory = 2'b10;
    end
  end

  assign sel_addr = (is_ldr || is_str) && !instr_q[24];

  assign mem_req  = live;
  assign ram_r_en = live && (is_ldr || is_ldr_lit);
  assign ram_w_en = live && is_str;
  assign mem_err  = mem_err_q;

  logic pass_down;
  assign pass_down    = cond_pass && !stall_mem && !abort;
  assign instr_output = pass_down ? instr_q : INSTR_NOP;
  assign opcode_out   = pass_down ? opcode_q : OP_NOP;
  assign pc_out       = pc_q;

endmodule
